// File: rtl/demux_dispatch_if.sv
// ---------------------------------------------------------------------------
// demux_dispatch_if
// Word-stream bundle between the shared ingress stage, the dispatch
// controller and the four consumer channels.
//   in_valid/in_ready/in_data/in_last/in_dest : upstream packet stream
//   out_valid[3:0]/out_ready[3:0]             : one-hot per-channel handshake
//   out_data/out_last                         : shared payload to all channels
// Modports:
//   slave  : the dispatch controller (accepts upstream, drives downstream)
//   master : the environment (drives upstream, consumes downstream)
// ---------------------------------------------------------------------------
interface demux_dispatch_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [1:0]    in_dest;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_data, in_last, in_dest, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, in_dest, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl
// Packet-level controller for the 1-to-4 demux. Each packet is routed to one
// channel (explicit in_dest or round-robin over enabled channels), the channel
// is held for the whole packet, and words pass through a one-entry output
// register tagged with its channel. Packets with no usable channel are
// swallowed and counted.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   rr_mode     : 1 = round-robin choice, 0 = use in_dest (packet start only)
//   ch_en[3:0]  : per-channel enable mask (packet start only)
//   bus         : stream bundle, controller side (slave modport)
//   busy        : a packet is open (forwarding or dropping)
//   drop_count  : saturating count of dropped packets
// ---------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rr_mode,
    input  logic [3:0]       ch_en,
    demux_dispatch_if.slave  bus,
    output logic             busy,
    output logic [CNTW-1:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic [1:0]      cur_ch_q,   cur_ch_d;
    logic [1:0]      rr_ptr_q,   rr_ptr_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
    logic            full_q,     full_d;
    logic [1:0]      tag_q,      tag_d;
    logic [DW-1:0]   data_q,     data_d;
    logic            last_q,     last_d;

    // Round-robin search: rot_idx[k] is the channel k steps above rr_ptr.
    logic [1:0] rot_idx [4];
    logic [3:0] rot_en;
    logic [3:0] out_valid_w;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = rr_ptr_q + 2'(gi);
            assign rot_en[gi]  = ch_en[rot_idx[gi]];
        end
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign out_valid_w[gi] = full_q && (tag_q == 2'(gi));
        end
    endgenerate

    logic       rr_found;
    logic [1:0] rr_cand;
    logic [1:0] cand;
    logic       cand_ok;
    logic       drop_now;
    logic       out_fire;
    logic       in_ready_w;
    logic       accept;

    // Nearest enabled channel wins, so the lowest rotation offset is checked last.
    always_comb begin
        rr_found = |rot_en;
        rr_cand  = rr_ptr_q;
        if (rot_en[3]) rr_cand = rot_idx[3];
        if (rot_en[2]) rr_cand = rot_idx[2];
        if (rot_en[1]) rr_cand = rot_idx[1];
        if (rot_en[0]) rr_cand = rot_idx[0];
    end

    assign cand     = rr_mode ? rr_cand  : bus.in_dest;
    assign cand_ok  = rr_mode ? rr_found : ch_en[bus.in_dest];
    assign drop_now = (state_q == IDLE) && !cand_ok;
    assign out_fire = full_q && bus.out_ready[tag_q];

    // A word being discarded never touches the output register, so it can be
    // taken even while the register is stalled.
    assign in_ready_w = (state_q == DROP) || drop_now || !full_q || bus.out_ready[tag_q];
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;
        full_d     = full_q;
        tag_d      = tag_q;
        data_d     = data_q;
        last_d     = last_q;

        if (out_fire) begin
            full_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (cand_ok) begin
                        cur_ch_d = cand;
                        tag_d    = cand;
                        full_d   = 1'b1;
                        data_d   = bus.in_data;
                        last_d   = bus.in_last;
                        if (rr_mode) begin
                            rr_ptr_d = cand + 2'd1;
                        end
                        if (!bus.in_last) begin
                            state_d = FWD;
                        end
                    end else begin
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + CNTW'(1);
                        end
                        if (!bus.in_last) begin
                            state_d = DROP;
                        end
                    end
                end
                FWD: begin
                    tag_d  = cur_ch_q;
                    full_d = 1'b1;
                    data_d = bus.in_data;
                    last_d = bus.in_last;
                    if (bus.in_last) begin
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (bus.in_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= 2'd0;
            rr_ptr_q   <= 2'd0;
            drop_cnt_q <= '0;
            full_q     <= 1'b0;
            tag_q      <= 2'd0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            full_q     <= full_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign busy          = (state_q != IDLE);
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_demux_dispatch_ctrl
// Directed, table-driven bench for demux_dispatch_ctrl (CNTW=2 so counter
// saturation is reachable quickly). Each table row is one clock cycle:
// inputs, the expected in_ready before the edge, and the expected outputs
// after the edge. Asynchronous reset is exercised by a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_demux_dispatch_ctrl;

    localparam int DW   = 8;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rr_mode;
    logic [3:0]      ch_en;
    logic            busy;
    logic [CNTW-1:0] drop_count;

    demux_dispatch_if #(.DW(DW)) bus ();

    demux_dispatch_ctrl #(.DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rr_mode    (rr_mode),
        .ch_en      (ch_en),
        .bus        (bus.slave),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rr;
        logic [3:0]      en;
        logic            v;
        logic [DW-1:0]   d;
        logic            l;
        logic [1:0]      dst;
        logic [3:0]      ordy;
        logic            e_irdy;
        logic [3:0]      e_ov;
        logic [DW-1:0]   e_od;
        logic            e_ol;
        logic            e_busy;
        logic [CNTW-1:0] e_dc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rr, input logic [3:0] en, input logic v, input logic [7:0] d,
                       input logic l, input logic [1:0] dst, input logic [3:0] ordy,
                       input logic e_irdy, input logic [3:0] e_ov, input logic [7:0] e_od,
                       input logic e_ol, input logic e_busy, input logic [1:0] e_dc);
        vec_t t;
        t.rr = rr; t.en = en; t.v = v; t.d = d; t.l = l; t.dst = dst; t.ordy = ordy;
        t.e_irdy = e_irdy; t.e_ov = e_ov; t.e_od = e_od; t.e_ol = e_ol;
        t.e_busy = e_busy; t.e_dc = e_dc;
        vecs.push_back(t);
    endtask

    // Drive one cycle, check in_ready combinationally, then outputs after the edge.
    task automatic apply(input vec_t t, input int idx);
        rr_mode       = t.rr;
        ch_en         = t.en;
        bus.in_valid  = t.v;
        bus.in_data   = t.d;
        bus.in_last   = t.l;
        bus.in_dest   = t.dst;
        bus.out_ready = t.ordy;
        #1;
        chk("in_ready", idx, 32'(bus.in_ready), 32'(t.e_irdy));
        @(posedge clk);
        #1;
        chk("out_valid", idx, 32'(bus.out_valid), 32'(t.e_ov));
        if (t.e_ov != 4'b0000) begin
            chk("out_data", idx, 32'(bus.out_data), 32'(t.e_od));
            chk("out_last", idx, 32'(bus.out_last), 32'(t.e_ol));
        end
        chk("busy", idx, 32'(busy), 32'(t.e_busy));
        chk("drop_count", idx, 32'(drop_count), 32'(t.e_dc));
        $display("step %0d: in_v=%0b d=%h last=%0b dst=%0d ordy=%b -> out_valid=%b out_data=%h busy=%0b drops=%0d",
                 idx, t.v, t.d, t.l, t.dst, t.ordy, bus.out_valid, bus.out_data, busy, drop_count);
    endtask

    initial begin
        vec_t h;

        rr_mode       = 1'b0;
        ch_en         = 4'b1111;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_dest   = 2'd0;
        bus.out_ready = 4'b1111;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 0, 32'(bus.out_data), 32'h0);
        chk("rst_out_last", 0, 32'(bus.out_last), 32'h0);
        chk("rst_busy", 0, 32'(busy), 32'h0);
        chk("rst_drop_count", 0, 32'(drop_count), 32'h0);
        chk("rst_in_ready", 0, 32'(bus.in_ready), 32'h1);
        rst = 1'b0;

        //   rr  en       v  d      l  dst  ordy      irdy ov       od     ol busy dc
        // explicit route to channel 2, 3 beats
        add(0, 4'b1111, 1, 8'h11, 0, 2'd2, 4'b1111, 1, 4'b0100, 8'h11, 0, 1, 2'd0);
        add(0, 4'b1111, 1, 8'h22, 0, 2'd0, 4'b1111, 1, 4'b0100, 8'h22, 0, 1, 2'd0);
        add(0, 4'b1111, 1, 8'h33, 1, 2'd0, 4'b1111, 1, 4'b0100, 8'h33, 1, 0, 2'd0);
        add(0, 4'b1111, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd0);
        // round robin over 1011: channels 0,1,3,0 (in_dest ignored)
        add(1, 4'b1011, 1, 8'hA0, 1, 2'd2, 4'b1111, 1, 4'b0001, 8'hA0, 1, 0, 2'd0);
        add(1, 4'b1011, 1, 8'hA1, 1, 2'd2, 4'b1111, 1, 4'b0010, 8'hA1, 1, 0, 2'd0);
        add(1, 4'b1011, 1, 8'hA2, 1, 2'd2, 4'b1111, 1, 4'b1000, 8'hA2, 1, 0, 2'd0);
        add(1, 4'b1011, 1, 8'hA3, 1, 2'd2, 4'b1111, 1, 4'b0001, 8'hA3, 1, 0, 2'd0);
        add(1, 4'b1011, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd0);
        // drop: dest 0 disabled, 2 beats; then dest 1 forwarded
        add(0, 4'b1110, 1, 8'hB0, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 1, 2'd1);
        add(0, 4'b1110, 1, 8'hB1, 1, 2'd1, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd1);
        add(0, 4'b1110, 1, 8'hC0, 1, 2'd1, 4'b1111, 1, 4'b0010, 8'hC0, 1, 0, 2'd1);
        add(0, 4'b1110, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd1);
        // backpressure on channel 3 for 4 cycles, other readies high
        add(0, 4'b1111, 1, 8'hD0, 0, 2'd3, 4'b0111, 1, 4'b1000, 8'hD0, 0, 1, 2'd1);
        add(0, 4'b1111, 1, 8'hD1, 0, 2'd3, 4'b0111, 0, 4'b1000, 8'hD0, 0, 1, 2'd1);
        add(0, 4'b1111, 1, 8'hD1, 0, 2'd3, 4'b0111, 0, 4'b1000, 8'hD0, 0, 1, 2'd1);
        add(0, 4'b1111, 1, 8'hD1, 0, 2'd3, 4'b0111, 0, 4'b1000, 8'hD0, 0, 1, 2'd1);
        add(0, 4'b1111, 1, 8'hD1, 0, 2'd3, 4'b1111, 1, 4'b1000, 8'hD1, 0, 1, 2'd1);
        add(0, 4'b1111, 1, 8'hD2, 1, 2'd3, 4'b1111, 1, 4'b1000, 8'hD2, 1, 0, 2'd1);
        add(0, 4'b1111, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd1);
        // round robin with no enabled channel drops; then saturate the 2-bit counter
        add(1, 4'b0000, 1, 8'hE0, 1, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd2);
        add(0, 4'b1110, 1, 8'hE1, 1, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd3);
        add(0, 4'b1110, 1, 8'hE2, 1, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd3);
        add(0, 4'b1110, 1, 8'hE3, 1, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd3);
        // rr_ptr untouched by drops and explicit packets: still points at 1
        add(1, 4'b1111, 1, 8'hE4, 1, 2'd3, 4'b1111, 1, 4'b0010, 8'hE4, 1, 0, 2'd3);
        add(1, 4'b1111, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd3);
        // mode/mask/dest changes mid-packet do not move the open packet
        add(0, 4'b1111, 1, 8'hF0, 0, 2'd2, 4'b1111, 1, 4'b0100, 8'hF0, 0, 1, 2'd3);
        add(1, 4'b0000, 1, 8'hF1, 1, 2'd0, 4'b1111, 1, 4'b0100, 8'hF1, 1, 0, 2'd3);
        add(0, 4'b1111, 0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0, 2'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i + 1);
        end

        // ---- asynchronous reset mid-packet with a stalled word in the register
        h.rr = 0; h.en = 4'b1111; h.v = 1; h.d = 8'h5A; h.l = 0; h.dst = 2'd1; h.ordy = 4'b0000;
        h.e_irdy = 1; h.e_ov = 4'b0010; h.e_od = 8'h5A; h.e_ol = 0; h.e_busy = 1; h.e_dc = 2'd3;
        apply(h, 100);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 101, 32'(bus.out_valid), 32'h0);
        chk("arst_drop_count", 101, 32'(drop_count), 32'h0);
        chk("arst_busy", 101, 32'(busy), 32'h0);
        chk("arst_out_data", 101, 32'(bus.out_data), 32'h0);
        $display("step 101: async reset mid-packet -> out_valid=%b busy=%0b drops=%0d",
                 bus.out_valid, busy, drop_count);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        #1;
        rst = 1'b0;

        // nothing of the discarded packet appears afterwards
        h.v = 0; h.ordy = 4'b1111; h.e_ov = 4'b0000; h.e_busy = 0; h.e_dc = 2'd0;
        for (int i = 0; i < 3; i++) begin
            apply(h, 102 + i);
        end

        // round-robin pointer restarts at channel 0 after reset
        h.rr = 1; h.en = 4'b1111; h.v = 1; h.d = 8'h77; h.l = 1; h.dst = 2'd3;
        h.e_irdy = 1; h.e_ov = 4'b0001; h.e_od = 8'h77; h.e_ol = 1; h.e_busy = 0; h.e_dc = 2'd0;
        apply(h, 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
